// File: rtl/cpu_pkg.sv
// Shared MIPS32 datapath constants: immediate-extension mode encodings,
// used by both the control decoder and the extension unit.
package cpu_pkg;

    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGN   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

endpackage

// File: rtl/ext_core_comb.sv
// Combinational immediate extender: zero, sign, upper placement (LUI) and
// branch offset (sign-extended word offset converted to a byte offset).
module ext_core_comb
    import cpu_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  a,
    output logic [OUT_W-1:0] y
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] branch;

    assign zext   = {{PAD_W{1'b0}}, a};
    assign sext   = {{PAD_W{a[IN_W-1]}}, a};
    assign upper  = {a, {PAD_W{1'b0}}};
    // The two bits shifted out of the top are dropped, i.e. truncation to OUT_W.
    assign branch = {sext[OUT_W-3:0], 2'b00};

    always_comb begin
        y = zext;
        case (mode)
            EXT_ZERO:   y = zext;
            EXT_SIGN:   y = sext;
            EXT_UPPER:  y = upper;
            EXT_BRANCH: y = branch;
            default:    y = zext;
        endcase
    end

endmodule

// File: rtl/ext_unit_pipe.sv
// Pipelined immediate-extension unit between decode and execute: the extended
// value, a valid bit and a destination tag travel through STAGES registers.
module ext_unit_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  a,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    output logic [OUT_W-1:0] y,
    output logic [TAG_W-1:0] tag_out
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $fatal(1, "ext_unit_pipe: STAGES must be in 1..4");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_width
        $fatal(1, "ext_unit_pipe: OUT_W must be at least IN_W + 2");
    end

    logic [OUT_W-1:0] ext_value;

    ext_core_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode (mode),
        .a    (a),
        .y    (ext_value)
    );

    // Stage 0 captures the freshly extended input; later stages are pure delay.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             v_q;
        logic [OUT_W-1:0] d_q;
        logic [TAG_W-1:0] t_q;
        logic             v_d;
        logic [OUT_W-1:0] d_d;
        logic [TAG_W-1:0] t_d;

        if (g == 0) begin : g_head
            assign v_d = valid_in;
            assign d_d = ext_value;
            assign t_d = tag_in;
        end else begin : g_tail
            assign v_d = g_stage[g-1].v_q;
            assign d_d = g_stage[g-1].d_q;
            assign t_d = g_stage[g-1].t_q;
        end

        // Flush clears data too, so a flushed pipe reads exactly like a reset one.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                v_q <= 1'b0;
                d_q <= '0;
                t_q <= '0;
            end else if (!stall) begin
                v_q <= v_d;
                d_q <= d_d;
                t_q <= t_d;
            end
        end
    end

    assign valid_out = g_stage[STAGES-1].v_q;
    assign y         = valid_out ? g_stage[STAGES-1].d_q : '0;
    assign tag_out   = valid_out ? g_stage[STAGES-1].t_q : '0;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed bench for ext_unit_pipe: STAGES=2 main instance plus STAGES=1 and
// STAGES=4 instances sharing the same stimulus for the latency checks.
module tb_ext_unit_pipe;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [4:0]  tag_in;

    logic        valid_out2, valid_out1, valid_out4;
    logic [31:0] y2, y1, y4;
    logic [4:0]  tag_out2, tag_out1, tag_out4;

    int checks;
    int errors;

    ext_unit_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_in(valid_in), .mode(mode), .a(a), .tag_in(tag_in),
        .valid_out(valid_out2), .y(y2), .tag_out(tag_out2)
    );

    ext_unit_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1), .TAG_W(5)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_in(valid_in), .mode(mode), .a(a), .tag_in(tag_in),
        .valid_out(valid_out1), .y(y1), .tag_out(tag_out1)
    );

    ext_unit_pipe #(.IN_W(16), .OUT_W(32), .STAGES(4), .TAG_W(5)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_in(valid_in), .mode(mode), .a(a), .tag_in(tag_in),
        .valid_out(valid_out4), .y(y4), .tag_out(tag_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_out2(input string name, input logic v, input logic [31:0] val, input logic [4:0] t);
        check({name, ".valid"}, {31'd0, valid_out2}, {31'd0, v});
        check({name, ".y"}, y2, val);
        check({name, ".tag"}, {27'd0, tag_out2}, {27'd0, t});
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] av, input logic [4:0] t);
        valid_in = v;
        mode     = m;
        a        = av;
        tag_in   = t;
    endtask

    // One isolated transaction through the STAGES=2 instance.
    task automatic run_one(input string name, input logic [1:0] m, input logic [15:0] av,
                           input logic [4:0] t, input logic [31:0] exp);
        drive(1'b1, m, av, t);
        tick();
        drive(1'b0, 2'b00, 16'h0000, 5'd0);
        check_out2({name, ".lat1"}, 1'b0, 32'h0, 5'd0);
        tick();
        check_out2(name, 1'b1, exp, t);
        tick();
        check_out2({name, ".after"}, 1'b0, 32'h0, 5'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        drive(1'b1, 2'b01, 16'hAAAA, 5'd9);
        tick();
        tick();
        check_out2("reset", 1'b0, 32'h0, 5'd0);
        rst = 1'b0;
        drive(1'b0, 2'b00, 16'h0000, 5'd0);
        tick();
        check_out2("idle", 1'b0, 32'h0, 5'd0);

        // Single SIGN transaction and the other modes
        run_one("sign_ffff",   2'b01, 16'hFFFF, 5'd3, 32'hFFFF_FFFF);
        run_one("zero_ffff",   2'b00, 16'hFFFF, 5'd7, 32'h0000_FFFF);
        run_one("upper_1234",  2'b10, 16'h1234, 5'd8, 32'h1234_0000);
        run_one("branch_fffe", 2'b11, 16'hFFFE, 5'd10, 32'hFFFF_FFF8);
        run_one("branch_7fff", 2'b11, 16'h7FFF, 5'd11, 32'h0001_FFFC);
        run_one("sign_7fff",   2'b01, 16'h7FFF, 5'd12, 32'h0000_7FFF);

        // Back-to-back stream with a two-cycle stall after the second accept
        drive(1'b1, 2'b01, 16'd1, 5'd1);
        tick();
        drive(1'b1, 2'b01, 16'd2, 5'd2);
        tick();
        check_out2("stream.e1", 1'b1, 32'd1, 5'd1);
        drive(1'b1, 2'b01, 16'd3, 5'd3);
        stall = 1'b1;
        tick();
        check_out2("stream.stall1", 1'b1, 32'd1, 5'd1);
        tick();
        check_out2("stream.stall2", 1'b1, 32'd1, 5'd1);
        stall = 1'b0;
        tick();
        check_out2("stream.e2", 1'b1, 32'd2, 5'd2);
        drive(1'b1, 2'b01, 16'd4, 5'd4);
        tick();
        check_out2("stream.e3", 1'b1, 32'd3, 5'd3);
        drive(1'b0, 2'b00, 16'h0000, 5'd0);
        tick();
        check_out2("stream.e4", 1'b1, 32'd4, 5'd4);
        tick();
        check_out2("stream.drain", 1'b0, 32'h0, 5'd0);

        // Flush together with stall while two entries are in flight
        drive(1'b1, 2'b01, 16'd5, 5'd5);
        tick();
        drive(1'b1, 2'b01, 16'd6, 5'd6);
        tick();
        check_out2("flush.pre", 1'b1, 32'd5, 5'd5);
        drive(1'b1, 2'b01, 16'd7, 5'd7);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 2'b00, 16'h0000, 5'd0);
        check_out2("flush.c1", 1'b0, 32'h0, 5'd0);
        tick();
        check_out2("flush.c2", 1'b0, 32'h0, 5'd0);
        tick();
        check_out2("flush.c3", 1'b0, 32'h0, 5'd0);

        // Reset pulsed mid-stream, then a fresh input right after
        drive(1'b1, 2'b01, 16'd8, 5'd8);
        tick();
        drive(1'b1, 2'b01, 16'd9, 5'd9);
        tick();
        check_out2("rst.pre", 1'b1, 32'd8, 5'd8);
        drive(1'b1, 2'b01, 16'd10, 5'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out2("rst.c1", 1'b0, 32'h0, 5'd0);
        drive(1'b1, 2'b01, 16'd11, 5'd11);
        tick();
        drive(1'b0, 2'b00, 16'h0000, 5'd0);
        check_out2("rst.lat1", 1'b0, 32'h0, 5'd0);
        tick();
        check_out2("rst.new", 1'b1, 32'd11, 5'd11);

        // Let every instance drain before the latency comparison
        for (int i = 0; i < 5; i++) tick();

        // Latency of the STAGES=1 and STAGES=4 builds
        drive(1'b1, 2'b01, 16'h8000, 5'd6);
        tick();
        drive(1'b0, 2'b00, 16'h0000, 5'd0);
        check("s1.valid", {31'd0, valid_out1}, 32'd1);
        check("s1.y", y1, 32'hFFFF_8000);
        check("s1.tag", {27'd0, tag_out1}, 32'd6);
        check("s4.early", {31'd0, valid_out4}, 32'd0);
        tick();
        check("s1.after", {31'd0, valid_out1}, 32'd0);
        check("s1.after_y", y1, 32'h0);
        tick();
        check("s4.lat3", {31'd0, valid_out4}, 32'd0);
        tick();
        check("s4.valid", {31'd0, valid_out4}, 32'd1);
        check("s4.y", y4, 32'hFFFF_8000);
        check("s4.tag", {27'd0, tag_out4}, 32'd6);
        tick();
        check("s4.after", {31'd0, valid_out4}, 32'd0);
        check("s4.after_y", y4, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
